// File: rtl/branch_resolve_ctrl.sv
// Purpose: sequences the external branch comparator and resolves conditional branches from decode.
// Latency: accept at edge T, res_valid/redirect in cycle T+CMP_LAT+1; one branch per CMP_LAT+2 cycles.
// Backpressure: o_br_ready is high only in IDLE; decode holds i_br_valid until it sees ready.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_br_valid/o_br_ready   branch handshake from decode/issue
//   i_br_funct3             000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
//   i_br_srca/i_br_srcb     rs1/rs2 values
//   i_br_pc/i_br_imm        branch PC and sign-extended B-immediate
//   i_br_pred_taken         fetch-side prediction
//   i_kill                  squash of the in-flight branch
//   o_cmp_srca/o_cmp_srcb   registered comparator operands
//   o_cmp_sel               comparator select: 000 EQ, 010 LT, 100 LTU
//   i_cmp_result            comparator output, valid CMP_LAT cycles after launch
//   o_res_valid/o_res_taken resolution pulse and actual outcome
//   o_redirect/o_redirect_pc mispredict pulse and refetch address
//   o_ill_br                pulse for reserved funct3 (010/011)
//   o_stat_*                saturating statistics counters (only with BRANCH_STATS_EN)
//
// Build option: define BRANCH_STATS_EN to add o_stat_branches, o_stat_taken, o_stat_mispred.
// CMP_LAT must be in 1..15 (the wait counter is 4 bits).

module branch_resolve_ctrl #(
   parameter int XLEN    = 64,
   parameter int CMP_LAT = 1,
   parameter int CNT_W   = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_br_valid,
   output logic            o_br_ready,
   input  logic [2:0]      i_br_funct3,
   input  logic [XLEN-1:0] i_br_srca,
   input  logic [XLEN-1:0] i_br_srcb,
   input  logic [XLEN-1:0] i_br_pc,
   input  logic [XLEN-1:0] i_br_imm,
   input  logic            i_br_pred_taken,
   input  logic            i_kill,
   output logic [XLEN-1:0] o_cmp_srca,
   output logic [XLEN-1:0] o_cmp_srcb,
   output logic [2:0]      o_cmp_sel,
   input  logic            i_cmp_result,
   output logic            o_res_valid,
   output logic            o_res_taken,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic            o_ill_br
`ifdef BRANCH_STATS_EN
   ,
   output logic [CNT_W-1:0] o_stat_branches,
   output logic [CNT_W-1:0] o_stat_taken,
   output logic [CNT_W-1:0] o_stat_mispred
`endif
);

   localparam logic [3:0] LP_CNT_INIT = 4'(CMP_LAT - 1);
   localparam logic [2:0] LP_SEL_EQ   = 3'b000;
   localparam logic [2:0] LP_SEL_LT   = 3'b010;
   localparam logic [2:0] LP_SEL_LTU  = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESOLVE = 2'd2
   } state_t;

   state_t          r_state;
   logic [3:0]      r_cnt;
   logic            r_br_ready;
   logic [XLEN-1:0] r_srca;
   logic [XLEN-1:0] r_srcb;
   logic [2:0]      r_sel;
   logic            r_inv;
   logic [XLEN-1:0] r_target;
   logic [XLEN-1:0] r_fall;
   logic            r_pred;
   logic            r_ill;
   logic            r_res_valid;
   logic            r_res_taken;
   logic            r_redirect;
   logic [XLEN-1:0] r_redirect_pc;

   logic            w_legal;
   logic [2:0]      w_sel;
   logic            w_taken;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_fall;

   // funct3 010/011 are the only reserved encodings.
   assign w_legal = (i_br_funct3[2:1] != 2'b01);

   // funct3[2:1] picks the primitive; funct3[0] marks the inverted forms (BNE/BGE/BGEU).
   always_comb begin
      w_sel = LP_SEL_EQ;
      case (i_br_funct3[2:1])
         2'b10:   w_sel = LP_SEL_LT;
         2'b11:   w_sel = LP_SEL_LTU;
         default: w_sel = LP_SEL_EQ;
      endcase
   end

   // Both addresses are computed at accept so resolve is a plain select; they wrap mod 2^XLEN.
   assign w_target = i_br_pc + i_br_imm;
   assign w_fall   = i_br_pc + XLEN'(4);

   assign w_taken  = i_cmp_result ^ r_inv;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_br_ready    <= 1'b1;
         r_srca        <= '0;
         r_srcb        <= '0;
         r_sel         <= '0;
         r_inv         <= 1'b0;
         r_target      <= '0;
         r_fall        <= '0;
         r_pred        <= 1'b0;
         r_ill         <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_taken   <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         // Pulse outputs default low; the state arms sets them for exactly one cycle.
         r_ill       <= 1'b0;
         r_res_valid <= 1'b0;
         r_redirect  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // i_kill is ignored here; a same-cycle accept still happens.
               if (i_br_valid) begin
                  if (w_legal) begin
                     r_srca     <= i_br_srca;
                     r_srcb     <= i_br_srcb;
                     r_sel      <= w_sel;
                     r_inv      <= i_br_funct3[0];
                     r_target   <= w_target;
                     r_fall     <= w_fall;
                     r_pred     <= i_br_pred_taken;
                     r_cnt      <= LP_CNT_INIT;
                     r_br_ready <= 1'b0;
                     r_state    <= ST_WAIT;
                  end else begin
                     // Reserved encoding: flag it and stay ready for the next branch.
                     r_ill <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (i_kill) begin
                  r_br_ready <= 1'b1;
                  r_state    <= ST_IDLE;
               end else if (r_cnt == 4'd0) begin
                  // Comparator output is valid on this edge (end of cycle T+CMP_LAT).
                  r_res_valid   <= 1'b1;
                  r_res_taken   <= w_taken;
                  r_redirect    <= (w_taken != r_pred);
                  r_redirect_pc <= w_taken ? r_target : r_fall;
                  r_state       <= ST_RESOLVE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESOLVE: begin
               r_br_ready <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_br_ready <= 1'b1;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_br_ready    = r_br_ready;
   assign o_cmp_srca    = r_srca;
   assign o_cmp_srcb    = r_srcb;
   assign o_cmp_sel     = r_sel;
   assign o_res_taken   = r_res_taken;
   assign o_redirect_pc = r_redirect_pc;
   assign o_ill_br      = r_ill;
   // A kill during the resolve cycle must win over the registered pulses.
   assign o_res_valid   = r_res_valid & ~i_kill;
   assign o_redirect    = r_redirect & ~i_kill;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] r_stat_branches;
   logic [CNT_W-1:0] r_stat_taken;
   logic [CNT_W-1:0] r_stat_mispred;

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stat_branches <= '0;
         r_stat_taken    <= '0;
         r_stat_mispred  <= '0;
      end else begin
         if (o_res_valid && (r_stat_branches != '1))
            r_stat_branches <= r_stat_branches + CNT_W'(1);
         if (o_res_valid && r_res_taken && (r_stat_taken != '1))
            r_stat_taken <= r_stat_taken + CNT_W'(1);
         if (o_redirect && (r_stat_mispred != '1))
            r_stat_mispred <= r_stat_mispred + CNT_W'(1);
      end
   end

   assign o_stat_branches = r_stat_branches;
   assign o_stat_taken    = r_stat_taken;
   assign o_stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: two instances (CMP_LAT=1 and CMP_LAT=3), a behavioural
// comparator with latency, and a queue of expected resolutions built from the ISA semantics.
// Latency: not applicable. Backpressure: stimulus waits for br_ready before driving.

module tb_branch_resolve_ctrl;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]  br_valid;
   logic [1:0]  kill;
   logic [2:0]  br_funct3;
   logic [63:0] br_srca, br_srcb, br_pc, br_imm;
   logic        br_pred;

   logic [1:0]  br_ready, res_valid, res_taken, redirect, ill_br, cmp_result;
   logic [63:0] cmp_srca [2];
   logic [63:0] cmp_srcb [2];
   logic [63:0] redirect_pc [2];
   logic [2:0]  cmp_sel [2];
`ifdef BRANCH_STATS_EN
   logic [31:0] st_br [2];
   logic [31:0] st_tk [2];
   logic [31:0] st_mp [2];
`endif

   branch_resolve_ctrl #(.XLEN(64), .CMP_LAT(LAT0), .CNT_W(32)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_br_valid(br_valid[0]), .o_br_ready(br_ready[0]),
      .i_br_funct3(br_funct3), .i_br_srca(br_srca), .i_br_srcb(br_srcb), .i_br_pc(br_pc),
      .i_br_imm(br_imm), .i_br_pred_taken(br_pred), .i_kill(kill[0]),
      .o_cmp_srca(cmp_srca[0]), .o_cmp_srcb(cmp_srcb[0]), .o_cmp_sel(cmp_sel[0]),
      .i_cmp_result(cmp_result[0]), .o_res_valid(res_valid[0]), .o_res_taken(res_taken[0]),
      .o_redirect(redirect[0]), .o_redirect_pc(redirect_pc[0]), .o_ill_br(ill_br[0])
`ifdef BRANCH_STATS_EN
      , .o_stat_branches(st_br[0]), .o_stat_taken(st_tk[0]), .o_stat_mispred(st_mp[0])
`endif
   );

   branch_resolve_ctrl #(.XLEN(64), .CMP_LAT(LAT1), .CNT_W(32)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_br_valid(br_valid[1]), .o_br_ready(br_ready[1]),
      .i_br_funct3(br_funct3), .i_br_srca(br_srca), .i_br_srcb(br_srcb), .i_br_pc(br_pc),
      .i_br_imm(br_imm), .i_br_pred_taken(br_pred), .i_kill(kill[1]),
      .o_cmp_srca(cmp_srca[1]), .o_cmp_srcb(cmp_srcb[1]), .o_cmp_sel(cmp_sel[1]),
      .i_cmp_result(cmp_result[1]), .o_res_valid(res_valid[1]), .o_res_taken(res_taken[1]),
      .o_redirect(redirect[1]), .o_redirect_pc(redirect_pc[1]), .o_ill_br(ill_br[1])
`ifdef BRANCH_STATS_EN
      , .o_stat_branches(st_br[1]), .o_stat_taken(st_tk[1]), .o_stat_mispred(st_mp[1])
`endif
   );

   // ---------------- comparator model ----------------
   // Output is the true comparison only once the operands have been stable for the
   // configured latency; before that it drives the complement so early sampling shows up.
   function automatic logic cmp_f(input logic [2:0] s, input logic [63:0] a, input logic [63:0] b);
      case (s)
         3'b000:  return a == b;
         3'b010:  return $signed(a) < $signed(b);
         3'b100:  return a < b;
         default: return 1'b0;
      endcase
   endfunction

   logic [130:0] last_key [2];
   logic [3:0]   age_r [2];
   logic [3:0]   age_c [2];

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         age_c[d] = ({cmp_sel[d], cmp_srca[d], cmp_srcb[d]} != last_key[d]) ? 4'd1 :
                    ((age_r[d] == 4'd15) ? 4'd15 : age_r[d] + 4'd1);
         cmp_result[d] = (int'(age_c[d]) >= ((d == 0) ? LAT0 : LAT1)) ?
                         cmp_f(cmp_sel[d], cmp_srca[d], cmp_srcb[d]) :
                         ~cmp_f(cmp_sel[d], cmp_srca[d], cmp_srcb[d]);
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            last_key[d] <= '0;
            age_r[d]    <= '0;
         end else begin
            last_key[d] <= {cmp_sel[d], cmp_srca[d], cmp_srcb[d]};
            age_r[d]    <= age_c[d];
         end
      end
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct packed {
      logic        taken;
      logic        redirect;
      logic [63:0] pc;
   } exp_t;

   exp_t sbq [$];
   int   checks = 0;
   int   failures = 0;
   int   exp_br = 0, exp_tk = 0, exp_mp = 0;
   logic [2:0] legal_f3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

   function automatic logic model_taken(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Drives one branch for a single accept edge; called at posedge+1, returns at posedge+1.
   task automatic drive(input int d, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] pc, input logic [63:0] imm, input logic pred, input bit push);
      exp_t e;
      br_funct3 = f3; br_srca = a; br_srcb = b; br_pc = pc; br_imm = imm; br_pred = pred;
      br_valid[d] = 1'b1;
      if (push) begin
         e.taken    = model_taken(f3, a, b);
         e.redirect = (e.taken != pred);
         e.pc       = e.taken ? (pc + imm) : (pc + 64'd4);
         sbq.push_back(e);
         if (d == 0) begin
            exp_br++;
            if (e.taken) exp_tk++;
            if (e.redirect) exp_mp++;
         end
      end
      @(posedge clk);
      #1;
      br_valid[d] = 1'b0;
   endtask

   // Observes up to 20 cycles for a resolution or redirect pulse; no judgement here.
   task automatic wait_res(input int d, output bit seen, output logic rv, output logic tk,
                           output logic rd, output logic [63:0] rpc, output int ncyc);
      seen = 0; rv = 0; tk = 0; rd = 0; rpc = '0; ncyc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (res_valid[d] || redirect[d]) begin
            seen = 1; rv = res_valid[d]; tk = res_taken[d]; rd = redirect[d];
            rpc = redirect_pc[d]; ncyc = i;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; br_valid = '0; kill = '0; br_funct3 = '0;
      br_srca = '0; br_srcb = '0; br_pc = '0; br_imm = '0; br_pred = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({br_ready[0], res_valid[0], redirect[0], ill_br[0], res_taken[0]} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_flags: ready/rv/rd/ill/tk=%b required 10000",
                  {br_ready[0], res_valid[0], redirect[0], ill_br[0], res_taken[0]});
      end
      checks++;
      if ({cmp_sel[0], cmp_srca[0], cmp_srcb[0], redirect_pc[0]} !== '0) begin
         failures++;
         $display("FAIL reset_regs: sel=%h a=%h b=%h rpc=%h required all zero",
                  cmp_sel[0], cmp_srca[0], cmp_srcb[0], redirect_pc[0]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (br_ready !== 2'b11) begin
         failures++; $display("FAIL reset_release_ready: got %b required 11", br_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit bad;
      drive(1, 3'b110, 64'd7, 64'd9, 64'h100, 64'h10, 1'b0, 0);
      checks++;
      if (br_ready[1] !== 1'b0) begin
         failures++; $display("FAIL midrst_accept: ready=%b required 0", br_ready[1]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({br_ready[1], cmp_sel[1], cmp_srca[1]} !== {1'b1, 3'b000, 64'd0}) begin
         failures++;
         $display("FAIL midrst_state: ready=%b sel=%b a=%h required 1 000 0",
                  br_ready[1], cmp_sel[1], cmp_srca[1]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_br = 0; exp_tk = 0; exp_mp = 0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (res_valid[1] || redirect[1]) bad = 1;
      end
      checks++;
      if (bad) begin
         failures++; $display("FAIL midrst_dropped: saw res_valid/redirect=1 required 0");
      end
      @(posedge clk); #1;
   endtask

   task automatic test_beq();
      bit seen; logic rv, tk, rd; logic [63:0] rpc; int n; exp_t e;
      checks++;
      if (br_ready[0] !== 1'b1) begin
         failures++; $display("FAIL beq_ready: got %b required 1", br_ready[0]);
      end
      drive(0, 3'b000, 64'd5, 64'd5, 64'h1000, 64'h40, 1'b0, 1);
      checks++;
      if ({cmp_sel[0], cmp_srca[0], cmp_srcb[0], br_ready[0]} !== {3'b000, 64'd5, 64'd5, 1'b0}) begin
         failures++;
         $display("FAIL beq_launch: sel=%b a=%h b=%h ready=%b required 000 5 5 0",
                  cmp_sel[0], cmp_srca[0], cmp_srcb[0], br_ready[0]);
      end
      wait_res(0, seen, rv, tk, rd, rpc, n);
      checks++;
      if (!seen || sbq.size() == 0) begin
         failures++; $display("FAIL beq_resolve: seen=%0d queued=%0d required 1 1", seen, sbq.size());
      end else begin
         e = sbq.pop_front();
         checks++;
         if ({rv, tk, rd} !== {1'b1, e.taken, e.redirect}) begin
            failures++; $display("FAIL beq_outcome: rv/tk/rd=%b%b%b required 1%b%b", rv, tk, rd, e.taken, e.redirect);
         end
         checks++;
         if (rpc !== e.pc) begin
            failures++; $display("FAIL beq_pc: got %h required %h", rpc, e.pc);
         end
         checks++;
         if (n != LAT0 + 1) begin
            failures++; $display("FAIL beq_latency: got %0d required %0d", n, LAT0 + 1);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_bgeu();
      bit seen; logic rv, tk, rd; logic [63:0] rpc; int n; exp_t e;
      drive(0, 3'b111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2000, 64'h100, 1'b1, 1);
      checks++;
      if (cmp_sel[0] !== 3'b100) begin
         failures++; $display("FAIL bgeu_sel: got %b required 100", cmp_sel[0]);
      end
      wait_res(0, seen, rv, tk, rd, rpc, n);
      checks++;
      if (!seen || sbq.size() == 0) begin
         failures++; $display("FAIL bgeu_resolve: seen=%0d queued=%0d required 1 1", seen, sbq.size());
      end else begin
         e = sbq.pop_front();
         checks++;
         if ({rv, tk, rd} !== {1'b1, e.taken, e.redirect}) begin
            failures++; $display("FAIL bgeu_outcome: rv/tk/rd=%b%b%b required 1%b%b", rv, tk, rd, e.taken, e.redirect);
         end
         checks++;
         if (rpc !== e.pc) begin
            failures++; $display("FAIL bgeu_pc: got %h required %h", rpc, e.pc);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_blt_lat3();
      int low_cnt, res_i; logic tk, rd; exp_t e;
      low_cnt = 0; res_i = 0; tk = 0; rd = 0;
      drive(1, 3'b100, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'h5000, 64'h20, 1'b1, 1);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (res_valid[1]) begin
            res_i = i; tk = res_taken[1]; rd = redirect[1];
         end
         if (br_ready[1]) break;
         low_cnt++;
      end
      checks++;
      if (low_cnt != 4) begin
         failures++; $display("FAIL blt_ready_low: got %0d cycles required 4", low_cnt);
      end
      checks++;
      if (sbq.size() == 0) begin
         failures++; $display("FAIL blt_queue: empty required 1 entry");
      end else begin
         e = sbq.pop_front();
         checks++;
         if ({res_i, tk, rd} !== {32'd4, e.taken, e.redirect}) begin
            failures++;
            $display("FAIL blt_outcome: cycle=%0d tk=%b rd=%b required 4 %b %b", res_i, tk, rd, e.taken, e.redirect);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_kill();
      bit seen; logic rv, tk, rd; logic [63:0] rpc; int n; exp_t e;
      // kill during WAIT
      drive(0, 3'b000, 64'd3, 64'd3, 64'h4000, 64'h8, 1'b0, 0);
      kill[0] = 1'b1;
      @(posedge clk); #1;
      kill[0] = 1'b0;
      @(negedge clk);
      checks++;
      if ({res_valid[0], redirect[0], br_ready[0]} !== 3'b001) begin
         failures++;
         $display("FAIL kill_wait: rv/rd/ready=%b required 001", {res_valid[0], redirect[0], br_ready[0]});
      end
      @(posedge clk); #1;
      // kill during RESOLVE
      drive(0, 3'b000, 64'd3, 64'd3, 64'h4000, 64'h8, 1'b0, 0);
      @(posedge clk); #1;
      kill[0] = 1'b1;
      @(negedge clk);
      checks++;
      if ({res_valid[0], redirect[0]} !== 2'b00) begin
         failures++; $display("FAIL kill_resolve: rv/rd=%b required 00", {res_valid[0], redirect[0]});
      end
      @(posedge clk); #1;
      kill[0] = 1'b0;
      // kill in IDLE is ignored: accept and resolve normally
      kill[0] = 1'b1;
      drive(0, 3'b001, 64'd3, 64'd4, 64'h4100, 64'h80, 1'b1, 1);
      kill[0] = 1'b0;
      wait_res(0, seen, rv, tk, rd, rpc, n);
      checks++;
      if (!seen || sbq.size() == 0) begin
         failures++; $display("FAIL kill_idle_resolve: seen=%0d queued=%0d required 1 1", seen, sbq.size());
      end else begin
         e = sbq.pop_front();
         checks++;
         if ({rv, tk, rd} !== {1'b1, e.taken, e.redirect}) begin
            failures++; $display("FAIL kill_idle_outcome: rv/tk/rd=%b%b%b required 1%b%b", rv, tk, rd, e.taken, e.redirect);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_illegal();
      bit seen; logic rv, tk, rd; logic [63:0] rpc; int n; exp_t e;
      drive(0, 3'b010, 64'd1, 64'd2, 64'h6000, 64'h10, 1'b0, 0);
      checks++;
      if ({ill_br[0], br_ready[0], res_valid[0]} !== 3'b110) begin
         failures++;
         $display("FAIL ill_pulse: ill/ready/rv=%b required 110", {ill_br[0], br_ready[0], res_valid[0]});
      end
      drive(0, 3'b110, 64'd2, 64'd3, 64'h3000, 64'h10, 1'b1, 1);
      checks++;
      if ({ill_br[0], br_ready[0]} !== 2'b00) begin
         failures++; $display("FAIL ill_next_accept: ill/ready=%b required 00", {ill_br[0], br_ready[0]});
      end
      wait_res(0, seen, rv, tk, rd, rpc, n);
      checks++;
      if (!seen || sbq.size() == 0) begin
         failures++; $display("FAIL ill_follow_resolve: seen=%0d queued=%0d required 1 1", seen, sbq.size());
      end else begin
         e = sbq.pop_front();
         checks++;
         if ({n, rv, tk, rd} !== {LAT0 + 1, 1'b1, e.taken, e.redirect}) begin
            failures++;
            $display("FAIL ill_follow_outcome: cycle=%0d rv/tk/rd=%b%b%b required %0d 1%b%b",
                     n, rv, tk, rd, LAT0 + 1, e.taken, e.redirect);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      bit seen; logic rv, tk, rd; logic [63:0] rpc; int n; exp_t e;
      drive(0, 3'b001, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b0, 1);
      wait_res(0, seen, rv, tk, rd, rpc, n);
      checks++;
      if (!seen || sbq.size() == 0) begin
         failures++; $display("FAIL wrap_resolve: seen=%0d queued=%0d required 1 1", seen, sbq.size());
      end else begin
         e = sbq.pop_front();
         checks++;
         if ({rv, tk, rd, rpc} !== {1'b1, e.taken, e.redirect, e.pc}) begin
            failures++;
            $display("FAIL wrap_pc: rv/tk/rd=%b%b%b pc=%h required 1%b%b %h", rv, tk, rd, rpc, e.taken, e.redirect, e.pc);
         end
      end
      @(posedge clk); #1;
`ifdef BRANCH_STATS_EN
      checks++;
      if (st_mp[0] !== 32'(exp_mp)) begin
         failures++; $display("FAIL wrap_stat_mispred: got %0d required %0d", st_mp[0], exp_mp);
      end
`endif
   endtask

   task automatic test_back_to_back();
      bit seen; logic rv, tk, rd; logic [63:0] rpc; int n, d; exp_t e;
      logic [63:0] a, b; logic [2:0] f3;
      for (int k = 0; k < 20; k++) begin
         d  = (k < 14) ? 0 : 1;
         f3 = legal_f3[$urandom_range(0, 5)];
         a  = {$urandom, $urandom};
         b  = ($urandom_range(0, 2) == 0) ? a : {$urandom, $urandom};
         checks++;
         if (br_ready[d] !== 1'b1) begin
            failures++; $display("FAIL b2b_ready[%0d]: got %b required 1", k, br_ready[d]);
         end
         drive(d, f3, a, b, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
         wait_res(d, seen, rv, tk, rd, rpc, n);
         checks++;
         if (!seen || sbq.size() == 0) begin
            failures++; $display("FAIL b2b_resolve[%0d]: seen=%0d queued=%0d required 1 1", k, seen, sbq.size());
         end else begin
            e = sbq.pop_front();
            checks++;
            if ({rv, tk, rd} !== {1'b1, e.taken, e.redirect} || (e.redirect && rpc !== e.pc) ||
                n != ((d == 0) ? LAT0 : LAT1) + 1) begin
               failures++;
               $display("FAIL b2b_outcome[%0d]: f3=%b rv/tk/rd=%b%b%b pc=%h cyc=%0d required 1%b%b %h %0d",
                        k, f3, rv, tk, rd, rpc, n, e.taken, e.redirect, e.pc, ((d == 0) ? LAT0 : LAT1) + 1);
            end
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef BRANCH_STATS_EN
   task automatic test_stats();
      checks++;
      if ({st_br[0], st_tk[0], st_mp[0]} !== {32'(exp_br), 32'(exp_tk), 32'(exp_mp)}) begin
         failures++;
         $display("FAIL stats: br/tk/mp=%0d/%0d/%0d required %0d/%0d/%0d",
                  st_br[0], st_tk[0], st_mp[0], exp_br, exp_tk, exp_mp);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid();
      test_beq();
      test_bgeu();
      test_blt_lat3();
      test_kill();
      test_illegal();
      test_wrap();
      test_back_to_back();
`ifdef BRANCH_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
